// File: rtl/esfa_run_sequencer.sv
// Batch run controller that drives ESFATop's doRun handshake, times each run and tallies results.
// Define ESFA_CYCLE_STATS_EN to add the minCycles/maxCycles run-length statistics outputs.

module esfa_run_sequencer #(
    parameter int CNT_W         = 32,
    parameter int RUNS_W        = 16,
    parameter int START_TIMEOUT = 64,
    parameter int RUN_TIMEOUT   = 2000000,
    parameter int GAP_CYCLES    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RUNS_W-1:0] numRuns,
    output logic              doRun,
    input  logic              isRunning,
    input  logic              wasSuccessful,
    output logic              busy,
    output logic              done,
    output logic              timeoutErr,
    output logic [RUNS_W-1:0] passCount,
    output logic [RUNS_W-1:0] failCount,
    output logic [CNT_W-1:0]  lastCycles,
    output logic [RUNS_W-1:0] runIndex
`ifdef ESFA_CYCLE_STATS_EN
    ,
    output logic [CNT_W-1:0]  minCycles,
    output logic [CNT_W-1:0]  maxCycles
`endif
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RUN_LIM   = CNT_W'(RUN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RUN_MAX   = CNT_W'(RUN_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LIM   = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RUN,
        GAP,
        DONE
    } state_t;

    state_t            state;
    logic [RUNS_W-1:0] num_runs_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    function automatic logic [RUNS_W-1:0] sat_runs(input logic [RUNS_W-1:0] v);
        return (&v) ? v : v + RUNS_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            doRun      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeoutErr <= 1'b0;
            passCount  <= '0;
            failCount  <= '0;
            lastCycles <= '0;
            runIndex   <= '0;
            num_runs_q <= '0;
            wait_cnt   <= '0;
            cyc_cnt    <= '0;
            gap_cnt    <= '0;
`ifdef ESFA_CYCLE_STATS_EN
            minCycles  <= '0;
            maxCycles  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        passCount  <= '0;
                        failCount  <= '0;
                        runIndex   <= '0;
                        timeoutErr <= 1'b0;
                        num_runs_q <= numRuns;
`ifdef ESFA_CYCLE_STATS_EN
                        minCycles  <= '1;
                        maxCycles  <= '0;
`endif
                        if (numRuns == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            doRun <= 1'b0;
                        end else begin
                            state    <= REQ;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            doRun    <= 1'b1;
                            wait_cnt <= '0;
                        end
                    end
                end

                // The detecting edge already saw isRunning high, so it is the first counted cycle.
                // A start timeout still consumes a run slot so the batch always terminates.
                REQ: begin
                    if (isRunning) begin
                        state   <= RUN;
                        cyc_cnt <= CNT_W'(1);
                    end else if (wait_cnt == START_LIM) begin
                        state      <= GAP;
                        doRun      <= 1'b0;
                        gap_cnt    <= '0;
                        timeoutErr <= 1'b1;
                        failCount  <= sat_runs(failCount);
                        runIndex   <= sat_runs(runIndex);
                    end else begin
                        wait_cnt <= sat_cnt(wait_cnt);
                    end
                end

                RUN: begin
                    if (!isRunning) begin
                        state      <= GAP;
                        doRun      <= 1'b0;
                        gap_cnt    <= '0;
                        lastCycles <= cyc_cnt;
                        runIndex   <= sat_runs(runIndex);
                        if (wasSuccessful) passCount <= sat_runs(passCount);
                        else               failCount <= sat_runs(failCount);
`ifdef ESFA_CYCLE_STATS_EN
                        if (cyc_cnt < minCycles) minCycles <= cyc_cnt;
                        if (cyc_cnt > maxCycles) maxCycles <= cyc_cnt;
`endif
                    end else if (cyc_cnt >= RUN_LIM) begin
                        state      <= GAP;
                        doRun      <= 1'b0;
                        gap_cnt    <= '0;
                        lastCycles <= RUN_MAX;
                        timeoutErr <= 1'b1;
                        failCount  <= sat_runs(failCount);
                        runIndex   <= sat_runs(runIndex);
                    end else begin
                        cyc_cnt <= sat_cnt(cyc_cnt);
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LIM) begin
                        if (runIndex == num_runs_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= REQ;
                            doRun    <= 1'b1;
                            wait_cnt <= '0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_esfa_run_sequencer.sv
// Self-checking bench for esfa_run_sequencer: directed scenarios plus randomized batches
// checked against a run-level reference model; honours ESFA_CYCLE_STATS_EN.

module tb_esfa_run_sequencer;

    localparam int CNT_W         = 32;
    localparam int RUNS_W        = 16;
    localparam int START_TIMEOUT = 64;
    localparam int RUN_TIMEOUT   = 200;
    localparam int GAP_CYCLES    = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [RUNS_W-1:0] numRuns = '0;
    logic              isRunning = 1'b0;
    logic              wasSuccessful = 1'b0;
    logic              doRun;
    logic              busy;
    logic              done;
    logic              timeoutErr;
    logic [RUNS_W-1:0] passCount;
    logic [RUNS_W-1:0] failCount;
    logic [CNT_W-1:0]  lastCycles;
    logic [RUNS_W-1:0] runIndex;
`ifdef ESFA_CYCLE_STATS_EN
    logic [CNT_W-1:0]  minCycles;
    logic [CNT_W-1:0]  maxCycles;
`endif

    esfa_run_sequencer #(
        .CNT_W(CNT_W),
        .RUNS_W(RUNS_W),
        .START_TIMEOUT(START_TIMEOUT),
        .RUN_TIMEOUT(RUN_TIMEOUT),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .numRuns(numRuns),
        .doRun(doRun),
        .isRunning(isRunning),
        .wasSuccessful(wasSuccessful),
        .busy(busy),
        .done(done),
        .timeoutErr(timeoutErr),
        .passCount(passCount),
        .failCount(failCount),
        .lastCycles(lastCycles),
        .runIndex(runIndex)
`ifdef ESFA_CYCLE_STATS_EN
        ,
        .minCycles(minCycles),
        .maxCycles(maxCycles)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Run-level reference model: each run is summarised by its isRunning-high length and result.
    int               exp_pass;
    int               exp_fail;
    int               exp_last;
    bit               exp_tmo;
    logic [CNT_W-1:0] exp_min;
    logic [CNT_W-1:0] exp_max;

    int run_d[8];
    int run_len[8];
    bit run_ok[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_pass = 0;
        exp_fail = 0;
        exp_tmo  = 1'b0;
        exp_min  = '1;
        exp_max  = '0;
    endtask

    task automatic model_run(input int len, input bit ok);
        if (len >= RUN_TIMEOUT) begin
            exp_fail++;
            exp_tmo  = 1'b1;
            exp_last = RUN_TIMEOUT;
        end else begin
            exp_last = len;
            if (ok) exp_pass++;
            else    exp_fail++;
            if (CNT_W'(len) < exp_min) exp_min = CNT_W'(len);
            if (CNT_W'(len) > exp_max) exp_max = CNT_W'(len);
        end
    endtask

    task automatic pulse_start(input int n);
        numRuns = RUNS_W'(n);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        numRuns = RUNS_W'($urandom);
    endtask

    task automatic wait_do_run(input logic level, input int limit, output int waited);
        waited = 0;
        while (doRun !== level && waited < limit) begin
            tick();
            waited++;
        end
        if (doRun !== level) waited = -1;
    endtask

    // Plays ESFATop for one run: optional start delay, len high cycles, then the result on the fall.
    task automatic engine_run(input int d, input int len, input bit ok, input bit poke);
        repeat (d) tick();
        isRunning     = 1'b1;
        wasSuccessful = ~ok;
        for (int k = 0; k < len; k++) begin
            if (poke && k == len / 2) begin
                start   = 1'b1;
                numRuns = RUNS_W'(7);
            end
            tick();
            start = 1'b0;
        end
        isRunning     = 1'b0;
        wasSuccessful = ok;
        tick();
        wasSuccessful = ~ok;
    endtask

    task automatic run_batch(input string name, input int n, input bit poke);
        int w;
        model_clear();
        pulse_start(n);
        vectors++;
        if (doRun !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s start_handshake: got doRun=%0b busy=%0b expected 1 1", name, doRun, busy);
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                wait_do_run(1'b1, 50, w);
                vectors++;
                if (w != GAP_CYCLES) begin
                    miscompares++;
                    $display("[TB] FAIL %s gap_len run %0d: got %0d expected %0d", name, i, w, GAP_CYCLES);
                end
            end
            engine_run(run_d[i], run_len[i], run_ok[i], poke && i == 0);
            model_run(run_len[i], run_ok[i]);
            vectors++;
            if (passCount !== RUNS_W'(exp_pass) || failCount !== RUNS_W'(exp_fail)) begin
                miscompares++;
                $display("[TB] FAIL %s counts run %0d: got pass=%0d fail=%0d expected pass=%0d fail=%0d",
                         name, i, passCount, failCount, exp_pass, exp_fail);
            end
            vectors++;
            if (lastCycles !== CNT_W'(exp_last) || runIndex !== RUNS_W'(i + 1)) begin
                miscompares++;
                $display("[TB] FAIL %s last_index run %0d: got last=%0d idx=%0d expected last=%0d idx=%0d",
                         name, i, lastCycles, runIndex, exp_last, i + 1);
            end
        end
        w = 0;
        while (done !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        vectors++;
        if (done !== 1'b1 || w != GAP_CYCLES) begin
            miscompares++;
            $display("[TB] FAIL %s done_latency: got done=%0b after %0d expected 1 after %0d", name, done, w, GAP_CYCLES);
        end
        vectors++;
        if (busy !== 1'b0 || doRun !== 1'b0 || timeoutErr !== exp_tmo || runIndex !== RUNS_W'(n)) begin
            miscompares++;
            $display("[TB] FAIL %s final_flags: got busy=%0b doRun=%0b tmo=%0b idx=%0d expected 0 0 %0b %0d",
                     name, busy, doRun, timeoutErr, runIndex, exp_tmo, n);
        end
`ifdef ESFA_CYCLE_STATS_EN
        vectors++;
        if (minCycles !== exp_min || maxCycles !== exp_max) begin
            miscompares++;
            $display("[TB] FAIL %s min_max: got %0d/%0d expected %0d/%0d", name, minCycles, maxCycles, exp_min, exp_max);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if ({doRun, busy, done, timeoutErr} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {doRun, busy, done, timeoutErr});
        end
        vectors++;
        if (passCount !== '0 || failCount !== '0 || runIndex !== '0 || lastCycles !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_counts: got %0d %0d %0d %0d expected all 0", passCount, failCount, runIndex, lastCycles);
        end
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || doRun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_hold: got busy=%0b doRun=%0b expected 0 0", busy, doRun);
        end
    endtask

    task automatic test_three_runs();
        for (int i = 0; i < 3; i++) begin
            run_d[i] = 2; run_len[i] = 100; run_ok[i] = 1'b1;
        end
        run_batch("three_runs", 3, 1'b0);
    endtask

    task automatic test_mixed_results();
        run_d[0] = 1; run_len[0] = 50; run_ok[0] = 1'b0;
        run_d[1] = 3; run_len[1] = 75; run_ok[1] = 1'b1;
        run_batch("mixed", 2, 1'b0);
    endtask

    task automatic test_start_timeout();
        int hi;
        int w;
        isRunning = 1'b0;
        pulse_start(1);
        hi = 0;
        while (doRun === 1'b1 && hi < 200) begin
            hi++;
            tick();
        end
        vectors++;
        if (hi != START_TIMEOUT) begin
            miscompares++;
            $display("[TB] FAIL start_tmo_len: got %0d expected %0d", hi, START_TIMEOUT);
        end
        vectors++;
        if (timeoutErr !== 1'b1 || failCount !== RUNS_W'(1) || passCount !== '0) begin
            miscompares++;
            $display("[TB] FAIL start_tmo_counts: got tmo=%0b fail=%0d pass=%0d expected 1 1 0", timeoutErr, failCount, passCount);
        end
        w = 0;
        while (done !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        vectors++;
        if (done !== 1'b1 || runIndex !== RUNS_W'(1)) begin
            miscompares++;
            $display("[TB] FAIL start_tmo_done: got done=%0b idx=%0d expected 1 1", done, runIndex);
        end
`ifdef ESFA_CYCLE_STATS_EN
        vectors++;
        if (minCycles !== '1 || maxCycles !== '0) begin
            miscompares++;
            $display("[TB] FAIL start_tmo_min_max: got %0d/%0d expected all-ones/0", minCycles, maxCycles);
        end
`endif
    endtask

    task automatic test_run_timeout();
        int hi;
        int w;
        pulse_start(1);
        isRunning = 1'b1;
        hi = 0;
        while (doRun === 1'b1 && hi < 400) begin
            tick();
            hi++;
        end
        vectors++;
        if (hi != RUN_TIMEOUT) begin
            miscompares++;
            $display("[TB] FAIL run_tmo_len: got %0d expected %0d", hi, RUN_TIMEOUT);
        end
        vectors++;
        if (lastCycles !== CNT_W'(RUN_TIMEOUT) || timeoutErr !== 1'b1 || failCount !== RUNS_W'(1) || passCount !== '0) begin
            miscompares++;
            $display("[TB] FAIL run_tmo_result: got last=%0d tmo=%0b fail=%0d pass=%0d expected %0d 1 1 0",
                     lastCycles, timeoutErr, failCount, passCount, RUN_TIMEOUT);
        end
        w = 0;
        while (done !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        isRunning     = 1'b0;
        wasSuccessful = 1'b1;
        repeat (5) tick();
        vectors++;
        if (passCount !== '0 || failCount !== RUNS_W'(1) || lastCycles !== CNT_W'(RUN_TIMEOUT) ||
            done !== 1'b1 || doRun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL late_fall: got pass=%0d fail=%0d last=%0d done=%0b doRun=%0b expected 0 1 %0d 1 0",
                     passCount, failCount, lastCycles, done, doRun, RUN_TIMEOUT);
        end
    endtask

    task automatic test_zero_runs();
        bit seen;
        pulse_start(0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || timeoutErr !== 1'b0 || failCount !== '0 || runIndex !== '0) begin
            miscompares++;
            $display("[TB] FAIL zero_from_done: got done=%0b busy=%0b tmo=%0b fail=%0d idx=%0d expected 1 0 0 0 0",
                     done, busy, timeoutErr, failCount, runIndex);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        pulse_start(0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_from_idle: got done=%0b busy=%0b expected 1 0", done, busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen |= (doRun !== 1'b0);
            tick();
        end
        vectors++;
        if (seen !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL zero_no_dorun: got seen=%0b done=%0b expected 0 1", seen, done);
        end
    endtask

    task automatic test_start_while_busy();
        run_d[0] = 0; run_len[0] = 30; run_ok[0] = 1'b1;
        run_d[1] = 2; run_len[1] = 12; run_ok[1] = 1'b0;
        run_batch("busy_start", 2, 1'b1);
    endtask

    task automatic test_random_batches();
        int n;
        for (int b = 0; b < 5; b++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                run_d[i]   = $urandom_range(0, 6);
                run_len[i] = $urandom_range(1, 150);
                run_ok[i]  = 1'($urandom_range(0, 1));
            end
            run_batch("random", n, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        int w;
        run_d[0] = 1; run_len[0] = 20; run_ok[0] = 1'b1;
        pulse_start(3);
        engine_run(1, 20, 1'b1, 1'b0);
        vectors++;
        if (passCount !== RUNS_W'(1)) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_pass: got %0d expected 1", passCount);
        end
        wait_do_run(1'b1, 50, w);
        isRunning = 1'b1;
        repeat (10) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++;
        if (doRun !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || passCount !== '0 || runIndex !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got doRun=%0b busy=%0b done=%0b pass=%0d idx=%0d expected all 0",
                     doRun, busy, done, passCount, runIndex);
        end
        repeat (5) tick();
        isRunning = 1'b0;
        tick();
        vectors++;
        if (doRun !== 1'b0 || busy !== 1'b0 || passCount !== '0 || failCount !== '0 || lastCycles !== '0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got doRun=%0b busy=%0b pass=%0d fail=%0d last=%0d expected all 0",
                     doRun, busy, passCount, failCount, lastCycles);
        end
    endtask

    initial begin
        exp_last = 0;
        model_clear();
        test_reset();
        test_three_runs();
        test_mixed_results();
        test_start_timeout();
        test_run_timeout();
        test_zero_runs();
        test_start_while_busy();
        test_random_batches();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
